// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - sequential truth-table driver/checker for inv/xor/nor/nand/nand3 gates
// Optional build macro: GATE_CHECK_STOP_ON_FAIL_EN (end the run at the first mismatching vector)
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] func,
  output logic [2:0] dut_in,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] fail_vec,
  output logic       bad_func
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] func_q, func_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] dut_in_q, dut_in_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_count_q, fail_count_d;
  logic [2:0] fail_vec_q, fail_vec_d;
  logic       bad_func_q, bad_func_d;

  logic [2:0] last_vec;
  logic       expected;
  logic       mismatch;
  logic       stop_now;

  // Ideal truth function of the selected gate for one input vector.
  function automatic logic ideal_out(input logic [2:0] f, input logic [2:0] v);
    logic r;
    case (f)
      3'd0:    r = ~v[0];
      3'd1:    r = v[0] ^ v[1];
      3'd2:    r = ~(v[0] | v[1]);
      3'd3:    r = ~(v[0] & v[1]);
      default: r = ~(v[0] & v[1] & v[2]);
    endcase
    return r;
  endfunction

  // Next-state and next-output logic for the IDLE/DRIVE/REPORT sequencer.
  always_comb begin
    state_d      = state_q;
    func_d       = func_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    dut_in_d     = dut_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    fail_vec_d   = fail_vec_q;
    bad_func_d   = bad_func_q;

    // Index of the final vector: 2 vectors for the inverter, 8 for nand3, 4 otherwise.
    case (func_q)
      3'd0:    last_vec = 3'd1;
      3'd4:    last_vec = 3'd7;
      default: last_vec = 3'd3;
    endcase

    expected = ideal_out(func_q, vec_q);
    // Case inequality so an unresolved X/Z output never counts as correct.
    mismatch = (dut_out !== expected);
    stop_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pass_d       = 1'b0;
          fail_count_d = 4'd0;
          fail_vec_d   = 3'd0;
          if (func <= 3'd4) begin
            func_d     = func;
            bad_func_d = 1'b0;
            vec_d      = 3'd0;
            cnt_d      = 8'd0;
            dut_in_d   = 3'd0;
            busy_d     = 1'b1;
            state_d    = DRIVE;
          end else begin
            bad_func_d = 1'b1;
            done_d     = 1'b1;
            state_d    = REPORT;
          end
        end
      end

      DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          if (mismatch) begin
            if (fail_count_q != 4'd15) begin
              fail_count_d = fail_count_q + 4'd1;
            end
            if (fail_count_q == 4'd0) begin
              fail_vec_d = vec_q;
            end
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
            stop_now = 1'b1;
`else
            stop_now = 1'b0;
`endif
          end
          cnt_d = 8'd0;
          if (vec_q == last_vec || stop_now) begin
            vec_d    = 3'd0;
            dut_in_d = 3'd0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_d   = (fail_count_d == 4'd0);
            state_d  = REPORT;
          end else begin
            vec_d    = vec_q + 3'd1;
            dut_in_d = vec_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      REPORT: begin
        // Start during the done cycle is deliberately dropped.
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        dut_in_d = 3'd0;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      func_q       <= 3'd0;
      vec_q        <= 3'd0;
      cnt_q        <= 8'd0;
      dut_in_q     <= 3'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= 4'd0;
      fail_vec_q   <= 3'd0;
      bad_func_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      func_q       <= func_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      dut_in_q     <= dut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      fail_vec_q   <= fail_vec_d;
      bad_func_q   <= bad_func_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_count_q;
  assign fail_vec   = fail_vec_q;
  assign bad_func   = bad_func_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - self-checking bench for gate_truth_checker
module tb_gate_truth_checker;

  localparam int S = 4;
`ifdef GATE_CHECK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] func = 3'd0;
  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass, bad_func;
  logic [3:0] fail_count;
  logic [2:0] fail_vec;

  logic [2:0] gate_kind = 3'd0;
  logic [7:0] flip = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] f;
    logic [7:0] m;
    int         done_cyc;
    bit         pass;
    int         cnt;
    int         vec;
    bit         bad;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  // Ideal gate output from plain integer arithmetic on the vector index.
  function automatic logic ref_gate(input logic [2:0] f, input logic [2:0] v);
    int x, a, b;
    x = int'(v);
    a = x % 2;
    b = (x / 2) % 2;
    case (f)
      3'd0:    return (a == 0);
      3'd1:    return ((a + b) % 2) == 1;
      3'd2:    return (a + b) == 0;
      3'd3:    return (a + b) != 2;
      default: return x != 7;
    endcase
  endfunction

  // Gate under test: ideal function with selected vectors inverted.
  assign dut_out = ref_gate(gate_kind, dut_in) ^ flip[dut_in];

  gate_truth_checker #(.SETTLE_CYCLES(S)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .func       (func),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .fail_vec   (fail_vec),
    .bad_func   (bad_func)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference result of a whole run from the truth-table rules.
  task automatic model(input logic [2:0] f, input logic [7:0] m, output vec_t e);
    int n;
    e.f = f; e.m = m; e.pass = 1'b0; e.cnt = 0; e.vec = 0; e.bad = 1'b0;
    if (f > 3'd4) begin
      e.bad = 1'b1;
      e.done_cyc = 1;
      return;
    end
    n = (f == 3'd0) ? 2 : ((f == 3'd4) ? 8 : 4);
    e.done_cyc = n * S + 1;
    for (int k = 0; k < n; k++) begin
      if (m[k]) begin
        if (e.cnt == 0) e.vec = k;
        e.cnt++;
        if (STOP) begin
          e.done_cyc = (k + 1) * S + 1;
          break;
        end
      end
    end
    if (e.cnt > 15) e.cnt = 15;
    e.pass = (e.cnt == 0);
  endtask

  task automatic run_and_check(input string nm, input vec_t e, input bit poke);
    int cyc;
    bit seq_err;
    @(negedge clk);
    func = e.f; gate_kind = e.f; flip = e.m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    seq_err = 1'b0;
    while (done !== 1'b1 && cyc < 400) begin
      if (busy !== 1'b1 || dut_in !== 3'((cyc - 1) / S)) seq_err = 1'b1;
      if (poke && cyc == 3) begin
        start = 1'b1;
        func = 3'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk({nm, " done_cycle"}, (done === 1'b1) ? cyc : -1, e.done_cyc);
    if (!e.bad) chk({nm, " drive_seq_err"}, int'(seq_err), 0);
    chk({nm, " busy_at_done"}, int'(busy), 0);
    chk({nm, " dut_in_at_done"}, int'(dut_in), 0);
    chk({nm, " pass"}, int'(pass), int'(e.pass));
    chk({nm, " fail_count"}, int'(fail_count), e.cnt);
    chk({nm, " fail_vec"}, int'(fail_vec), e.vec);
    chk({nm, " bad_func"}, int'(bad_func), int'(e.bad));
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " done_one_cycle"}, int'(done), 0);
    chk({nm, " busy_after_done"}, int'(busy), 0);
    @(negedge clk);
    chk({nm, " no_restart"}, int'(busy) + int'(done), 0);
    chk({nm, " pass_held"}, int'(pass), int'(e.pass));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " done"}, int'(done), 0);
    chk({nm, " pass"}, int'(pass), 0);
    chk({nm, " fail_count"}, int'(fail_count), 0);
    chk({nm, " fail_vec"}, int'(fail_vec), 0);
    chk({nm, " bad_func"}, int'(bad_func), 0);
    chk({nm, " dut_in"}, int'(dut_in), 0);
  endtask

  initial begin
    vec_t e;
    tbl[0]  = '{3'd4, 8'h00, 33, 1'b1, 0, 0, 1'b0};
    tbl[1]  = '{3'd0, 8'h02, 9, 1'b0, 1, 1, 1'b0};
    tbl[2]  = '{3'd1, 8'h08, 17, 1'b0, 1, 3, 1'b0};
    tbl[3]  = '{3'd6, 8'h00, 1, 1'b0, 0, 0, 1'b1};
    tbl[4]  = '{3'd2, 8'h00, 17, 1'b1, 0, 0, 1'b0};
    tbl[5]  = '{3'd3, 8'h06, STOP ? 9 : 17, 1'b0, STOP ? 1 : 2, 1, 1'b0};
    tbl[6]  = '{3'd4, 8'hFF, STOP ? 5 : 33, 1'b0, STOP ? 1 : 8, 0, 1'b0};
    tbl[7]  = '{3'd7, 8'h00, 1, 1'b0, 0, 0, 1'b1};
    tbl[8]  = '{3'd5, 8'h00, 1, 1'b0, 0, 0, 1'b1};
    tbl[9]  = '{3'd0, 8'h01, STOP ? 5 : 9, 1'b0, 1, 0, 1'b0};
    tbl[10] = '{3'd4, 8'h90, STOP ? 21 : 33, 1'b0, STOP ? 1 : 2, 4, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_and_check($sformatf("tbl%0d", i), tbl[i], 1'b0);
    end

    // start pulses while busy and on the done cycle must be ignored
    model(3'd2, 8'h00, e);
    run_and_check("nor_poke", e, 1'b1);

    // reset in the middle of vector 2
    @(negedge clk);
    func = 3'd3; gate_kind = 3'd3; flip = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrun dut_in_vec2", int'(dut_in), 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrun_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrun idle_after_reset", int'(busy), 0);
    model(3'd3, 8'h00, e);
    run_and_check("rerun", e, 1'b0);

    for (int i = 0; i < 25; i++) begin
      model(3'($urandom_range(0, 7)), 8'($urandom), e);
      run_and_check($sformatf("rand%0d_f%0d_m%0h", i, e.f, e.m), e, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
